// File: rtl/id_operand_stage.sv
// ID-stage operand resolution with GPR read, forwarding, load scoreboard and ID/EX register.
// Optional build macro ID_REG0_ZERO_EN makes register 0 a hard-wired zero.
module id_operand_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_N      = 2,
  parameter int LD_LAT     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [REG_ADDR_W-1:0]         in_ra_addr,
  input  logic [REG_ADDR_W-1:0]         in_rb_addr,
  input  logic [REG_ADDR_W-1:0]         in_dst_addr,
  input  logic                          in_gpr_we_,
  input  logic                          in_is_load,
  output logic                          in_ready,
  output logic [REG_ADDR_W-1:0]         gpr_rd_addr_0,
  output logic [REG_ADDR_W-1:0]         gpr_rd_addr_1,
  input  logic [DATA_W-1:0]             gpr_rd_data_0,
  input  logic [DATA_W-1:0]             gpr_rd_data_1,
  input  logic [FWD_N-1:0]              fwd_we_,
  input  logic [FWD_N*REG_ADDR_W-1:0]   fwd_addr,
  input  logic [FWD_N*DATA_W-1:0]       fwd_data,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          ld_hazard,
  output logic                          id_en,
  output logic [DATA_W-1:0]             id_ra_data,
  output logic [DATA_W-1:0]             id_rb_data,
  output logic [REG_ADDR_W-1:0]         id_dst_addr,
  output logic                          id_gpr_we_,
  output logic                          id_is_load
);

  localparam int                    REG_N    = 1 << REG_ADDR_W;
  localparam logic [2:0]            LD_LAT_C = 3'(LD_LAT);
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
`ifdef ID_REG0_ZERO_EN
  localparam logic                  REG0_ZERO = 1'b1;
`else
  localparam logic                  REG0_ZERO = 1'b0;
`endif

  logic [2:0]            cnt_r [REG_N];
  logic                  id_en_r;
  logic [DATA_W-1:0]     id_ra_data_r;
  logic [DATA_W-1:0]     id_rb_data_r;
  logic [REG_ADDR_W-1:0] id_dst_addr_r;
  logic                  id_gpr_we_r;
  logic                  id_is_load_r;

  logic                  ra_pend_s;
  logic                  rb_pend_s;
  logic                  ld_hazard_s;
  logic                  capture_s;
  logic                  sb_set_s;
  logic                  dst_we_n_s;
  logic [DATA_W-1:0]     ra_data_s;
  logic [DATA_W-1:0]     rb_data_s;

  // Lowest-index valid forwarding match wins, so scan from the highest index down.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_ADDR_W-1:0]       addr,
    input logic [DATA_W-1:0]           gpr_data,
    input logic [FWD_N-1:0]            we_n,
    input logic [FWD_N*REG_ADDR_W-1:0] f_addr,
    input logic [FWD_N*DATA_W-1:0]     f_data
  );
    logic [DATA_W-1:0] res;
    res = gpr_data;
    for (int i = FWD_N - 1; i >= 0; i--) begin
      if (!we_n[i] && (f_addr[i*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
        res = f_data[i*DATA_W +: DATA_W];
      end
    end
    if (REG0_ZERO && (addr == REG_ZERO)) begin
      res = {DATA_W{1'b0}};
    end
    return res;
  endfunction

  assign gpr_rd_addr_0 = in_ra_addr;
  assign gpr_rd_addr_1 = in_rb_addr;
  assign ld_hazard     = ld_hazard_s;
  assign in_ready      = ~stall & ~ld_hazard_s & ~flush;
  assign id_en         = id_en_r;
  assign id_ra_data    = id_ra_data_r;
  assign id_rb_data    = id_rb_data_r;
  assign id_dst_addr   = id_dst_addr_r;
  assign id_gpr_we_    = id_gpr_we_r;
  assign id_is_load    = id_is_load_r;

  // Hazard detection, operand selection and capture/scoreboard-set qualifiers.
  always_comb begin
    ra_pend_s   = (cnt_r[in_ra_addr] != 3'd0) & ~(REG0_ZERO & (in_ra_addr == REG_ZERO));
    rb_pend_s   = (cnt_r[in_rb_addr] != 3'd0) & ~(REG0_ZERO & (in_rb_addr == REG_ZERO));
    ld_hazard_s = in_valid & (ra_pend_s | rb_pend_s);
    capture_s   = in_valid & ~ld_hazard_s & ~stall & ~flush;
    dst_we_n_s  = in_gpr_we_ | (REG0_ZERO & (in_dst_addr == REG_ZERO));
    sb_set_s    = capture_s & in_is_load & ~dst_we_n_s;
    ra_data_s   = resolve(in_ra_addr, gpr_rd_data_0, fwd_we_, fwd_addr, fwd_data);
    rb_data_s   = resolve(in_rb_addr, gpr_rd_data_1, fwd_we_, fwd_addr, fwd_data);
  end

  // ID/EX pipeline register: flush beats stall, stall beats hazard bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_en_r       <= 1'b0;
      id_ra_data_r  <= {DATA_W{1'b0}};
      id_rb_data_r  <= {DATA_W{1'b0}};
      id_dst_addr_r <= REG_ZERO;
      id_gpr_we_r   <= 1'b1;
      id_is_load_r  <= 1'b0;
    end else if (flush) begin
      id_en_r       <= 1'b0;
      id_gpr_we_r   <= 1'b1;
      id_is_load_r  <= 1'b0;
    end else if (stall) begin
      id_en_r       <= id_en_r;
      id_gpr_we_r   <= id_gpr_we_r;
      id_is_load_r  <= id_is_load_r;
    end else if (capture_s) begin
      id_en_r       <= 1'b1;
      id_ra_data_r  <= ra_data_s;
      id_rb_data_r  <= rb_data_s;
      id_dst_addr_r <= in_dst_addr;
      id_gpr_we_r   <= dst_we_n_s;
      id_is_load_r  <= in_is_load;
    end else begin
      id_en_r       <= 1'b0;
      id_gpr_we_r   <= 1'b1;
      id_is_load_r  <= 1'b0;
    end
  end

  // Load scoreboard: the register being loaded takes LD_LAT; others count down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        cnt_r[i] <= 3'd0;
      end
    end else if (flush) begin
      for (int i = 0; i < REG_N; i++) begin
        cnt_r[i] <= 3'd0;
      end
    end else if (!stall) begin
      for (int i = 0; i < REG_N; i++) begin
        if (sb_set_s && (in_dst_addr == REG_ADDR_W'(i))) begin
          cnt_r[i] <= LD_LAT_C;
        end else if (cnt_r[i] != 3'd0) begin
          cnt_r[i] <= cnt_r[i] - 3'd1;
        end else begin
          cnt_r[i] <= 3'd0;
        end
      end
    end else begin
      for (int i = 0; i < REG_N; i++) begin
        cnt_r[i] <= cnt_r[i];
      end
    end
  end

endmodule
